// File: rtl/cnn_stream_host_if.sv
// Load/result stream bundle between the interconnect and cnn_stream_host.
// The host is the slave on the load stream and the master on the result stream.
interface cnn_stream_host_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CLASSES  = 4,
  parameter int FC_MAC_WIDTH = 32
);
  localparam int CLS_W = $clog2(NUM_CLASSES);

  logic                           s_valid;
  logic                           s_ready;
  logic [DATA_WIDTH-1:0]          s_data;
  logic                           s_last;
  logic                           m_valid;
  logic                           m_ready;
  logic [CLS_W-1:0]               m_class;
  logic signed [FC_MAC_WIDTH-1:0] m_score;

  modport slave  (input  s_valid, s_data, s_last, m_ready,
                  output s_ready, m_valid, m_class, m_score);
  modport master (output s_valid, s_data, s_last, m_ready,
                  input  s_ready, m_valid, m_class, m_score);
endinterface

// File: rtl/cnn_stream_host.sv
// Host-side initiator for the CNN accelerator: deserialises a byte frame into
// the ifmap/kernel arrays, runs the accelerator, then argmaxes its FC scores
// and returns the winning class on the result stream.
module cnn_stream_host #(
  parameter int DATA_WIDTH   = 8,
  parameter int IFMAP_SIZE   = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int NUM_CLASSES  = 4,
  parameter int FC_MAC_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  cnn_stream_host_if.slave               bus,
  output logic [DATA_WIDTH-1:0]          ifmap_o   [0:IFMAP_SIZE-1][0:IFMAP_SIZE-1],
  output logic signed [DATA_WIDTH-1:0]   weights_o [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
  output logic                           acc_en,
  input  logic                           acc_done,
  input  logic signed [FC_MAC_WIDTH-1:0] fc_out_i  [0:NUM_CLASSES-1],
  output logic                           busy,
  output logic                           frame_err
);
  localparam int IF_BEATS = IFMAP_SIZE * IFMAP_SIZE;
  localparam int TOTAL    = IF_BEATS + KERNEL_SIZE * KERNEL_SIZE;
  localparam int CNT_W    = $clog2(TOTAL);
  localparam int CLS_W    = $clog2(NUM_CLASSES);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TOTAL - 1);
  localparam logic [CLS_W-1:0] LAST_CLS  = CLS_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {LOAD, RUN, SCAN, OUT} state_t;

  state_t                         state, state_n;
  logic [CNT_W-1:0]               cnt;
  logic                           accept, is_last, bad, beat_ok, take;
  logic signed [FC_MAC_WIDTH-1:0] score [0:NUM_CLASSES-1];
  logic signed [FC_MAC_WIDTH-1:0] best, res_score;
  logic [CLS_W-1:0]               best_idx, idx, res_class;

  // Beat qualification: a beat whose s_last disagrees with its position is dropped
  always_comb begin
    accept  = bus.s_valid && (state == LOAD);
    is_last = (cnt == LAST_BEAT);
    bad     = accept && (bus.s_last != is_last);
    beat_ok = accept && !bad;
    take    = score[idx] > best;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= LOAD;
    else        state <= state_n;
  end

  // Next state and Moore outputs
  always_comb begin
    state_n     = state;
    bus.s_ready = 1'b0;
    acc_en      = 1'b0;
    bus.m_valid = 1'b0;
    busy        = 1'b1;
    case (state)
      LOAD: begin
        bus.s_ready = 1'b1;
        busy        = 1'b0;
        if (beat_ok && is_last) state_n = RUN;
      end
      RUN: begin
        acc_en = 1'b1;
        if (acc_done) state_n = SCAN;
      end
      SCAN: if (idx == LAST_CLS) state_n = OUT;
      OUT: begin
        bus.m_valid = 1'b1;
        if (bus.m_ready) state_n = LOAD;
      end
      default: state_n = LOAD;
    endcase
  end

  // Beat counter and framing-error pulse; a good last beat wraps the counter to 0
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= bad;
      if (bad)          cnt <= '0;
      else if (beat_ok) cnt <= is_last ? '0 : cnt + CNT_W'(1);
    end
  end

  // Frame deserialiser: ifmap beats first, then kernel, both row-major
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < IFMAP_SIZE; r++)
        for (int c = 0; c < IFMAP_SIZE; c++) ifmap_o[r][c] <= '0;
      for (int r = 0; r < KERNEL_SIZE; r++)
        for (int c = 0; c < KERNEL_SIZE; c++) weights_o[r][c] <= '0;
    end else if (beat_ok) begin
      for (int r = 0; r < IFMAP_SIZE; r++)
        for (int c = 0; c < IFMAP_SIZE; c++)
          if (cnt == CNT_W'(r * IFMAP_SIZE + c)) ifmap_o[r][c] <= bus.s_data;
      for (int r = 0; r < KERNEL_SIZE; r++)
        for (int c = 0; c < KERNEL_SIZE; c++)
          if (cnt == CNT_W'(IF_BEATS + r * KERNEL_SIZE + c))
            weights_o[r][c] <= $signed(bus.s_data);
    end
  end

  // Score capture on first acc_done, then one-class-per-cycle argmax; strict >
  // keeps the lowest index on ties
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CLASSES; i++) score[i] <= '0;
      best      <= '0;
      best_idx  <= '0;
      idx       <= '0;
      res_class <= '0;
      res_score <= '0;
    end else begin
      case (state)
        RUN: if (acc_done) begin
          for (int i = 0; i < NUM_CLASSES; i++) score[i] <= fc_out_i[i];
          best     <= fc_out_i[0];
          best_idx <= '0;
          idx      <= CLS_W'(1);
        end
        SCAN: begin
          if (take) begin
            best     <= score[idx];
            best_idx <= idx;
          end
          idx <= idx + CLS_W'(1);
          if (idx == LAST_CLS) begin
            res_class <= take ? idx : best_idx;
            res_score <= take ? score[idx] : best;
          end
        end
        default: ;
      endcase
    end
  end

  // Result payload persists past the handshake until the next result
  assign bus.m_class = res_class;
  assign bus.m_score = res_score;
endmodule

// File: tb/tb_cnn_stream_host.sv
// Directed bench for cnn_stream_host: a transaction-level model predicts all
// outputs every cycle, and literal expectations pin key values.
module tb_cnn_stream_host;
  localparam int DW = 8, IS = 8, KS = 3, NC = 4, FW = 32;
  localparam int TOTAL = IS * IS + KS * KS;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cnn_stream_host_if #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .FC_MAC_WIDTH(FW)) bus ();

  logic [DW-1:0]        ifmap_o   [0:IS-1][0:IS-1];
  logic signed [DW-1:0] weights_o [0:KS-1][0:KS-1];
  logic                 acc_en, acc_done, busy, frame_err;
  logic signed [FW-1:0] fc_out_i  [0:NC-1];

  cnn_stream_host #(.DATA_WIDTH(DW), .IFMAP_SIZE(IS), .KERNEL_SIZE(KS),
                    .NUM_CLASSES(NC), .FC_MAC_WIDTH(FW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .ifmap_o(ifmap_o), .weights_o(weights_o),
    .acc_en(acc_en), .acc_done(acc_done), .fc_out_i(fc_out_i),
    .busy(busy), .frame_err(frame_err)
  );

  int checks = 0, errors = 0;

  task automatic chk(string nm, logic signed [63:0] act, logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // phase: 0 loading, 1 accelerator running, 2 argmax in progress, 3 result out
  int     m_ph, m_beats, m_cd, m_cls, m_pcls;
  longint m_score, m_pscore;
  bit     m_err, chk_en = 1'b0;
  int     m_if [0:IS-1][0:IS-1];
  int     m_w  [0:KS-1][0:KS-1];

  always @(posedge clk) begin
    if (!reset) begin
      m_ph = 0; m_beats = 0; m_cd = 0; m_err = 0;
      m_cls = 0; m_score = 0; m_pcls = 0; m_pscore = 0;
      for (int r = 0; r < IS; r++) for (int c = 0; c < IS; c++) m_if[r][c] = 0;
      for (int r = 0; r < KS; r++) for (int c = 0; c < KS; c++) m_w[r][c] = 0;
      chk_en = 1'b1;
    end else begin
      m_err = 0;
      case (m_ph)
        0: if (bus.s_valid) begin
          if (bus.s_last != (m_beats == TOTAL - 1)) begin
            m_err = 1; m_beats = 0;
          end else begin
            if (m_beats < IS * IS) m_if[m_beats / IS][m_beats % IS] = int'(bus.s_data);
            else m_w[(m_beats - IS * IS) / KS][(m_beats - IS * IS) % KS] = int'($signed(bus.s_data));
            if (m_beats == TOTAL - 1) begin m_ph = 1; m_beats = 0; end
            else m_beats++;
          end
        end
        1: if (acc_done) begin
          m_pcls = 0; m_pscore = fc_out_i[0];
          for (int i = 1; i < NC; i++)
            if (fc_out_i[i] > m_pscore) begin m_pscore = fc_out_i[i]; m_pcls = i; end
          m_ph = 2; m_cd = NC - 1;
        end
        2: begin
          m_cd--;
          if (m_cd == 0) begin m_ph = 3; m_cls = m_pcls; m_score = m_pscore; end
        end
        3: if (bus.m_ready) m_ph = 0;
        default: ;
      endcase
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      int nbad;
      chk("s_ready",   bus.s_ready, m_ph == 0);
      chk("acc_en",    acc_en,      m_ph == 1);
      chk("busy",      busy,        m_ph != 0);
      chk("m_valid",   bus.m_valid, m_ph == 3);
      chk("frame_err", frame_err,   m_err);
      chk("m_class",   bus.m_class, m_cls);
      chk("m_score",   bus.m_score, m_score);
      nbad = 0;
      for (int r = 0; r < IS; r++)
        for (int c = 0; c < IS; c++) if (int'(ifmap_o[r][c]) != m_if[r][c]) nbad++;
      for (int r = 0; r < KS; r++)
        for (int c = 0; c < KS; c++) if (int'(weights_o[r][c]) != m_w[r][c]) nbad++;
      chk("arrays", nbad, 0);
    end
  end

  // ---------------- stimulus ----------------
  int wpat [0:8] = '{1, 0, -1, 1, 0, -1, 1, 0, -1};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Beat k carries k+seed (ifmap) or wpat+seed (kernel); s_last only at last_at
  task automatic send_frame(int seed, int nbeats, int last_at);
    for (int k = 0; k < nbeats; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = (k < IS * IS) ? 8'(k + seed) : 8'(wpat[k - IS * IS] + seed);
      bus.s_last  = (k == last_at);
      tick();
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic finish_job(int rdelay, int f0, int f1, int f2, int f3,
                            bit early_ready, bit do_ack, int exp_cls, int exp_score);
    int n;
    repeat (rdelay) tick();
    fc_out_i[0] = f0; fc_out_i[1] = f1; fc_out_i[2] = f2; fc_out_i[3] = f3;
    acc_done = 1'b1;
    if (early_ready) bus.m_ready = 1'b1;
    tick();
    acc_done = 1'b0;
    chk("acc_en_after_done", acc_en, 0);
    n = 0;
    while (!bus.m_valid && n < 20) begin tick(); n++; end
    chk("m_valid_latency", n, NC - 1);
    chk("lit_class", bus.m_class, exp_cls);
    chk("lit_score", bus.m_score, exp_score);
    if (do_ack) begin
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0;
      chk("ack_s_ready", bus.s_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b1; bus.s_data = 8'hAA; bus.s_last = 1'b1; bus.m_ready = 1'b0;
    acc_done = 1'b0;
    for (int i = 0; i < NC; i++) fc_out_i[i] = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1; bus.s_valid = 1'b0; bus.s_last = 1'b0;
    chk("reset_s_ready", bus.s_ready, 1);
    chk("reset_acc_en",  acc_en, 0);
    chk("reset_ifmap",   ifmap_o[0][0], 0);

    // Nominal frame and result
    send_frame(0, TOTAL, TOTAL - 1);
    chk("acc_en_after_last", acc_en, 1);
    chk("ifmap_7_7",   ifmap_o[7][7], 63);
    chk("ifmap_1_2",   ifmap_o[1][2], 10);
    chk("weights_0_2", weights_o[0][2], -1);
    chk("weights_2_0", weights_o[2][0], 1);
    finish_job(4, -3, 17, 9, -40, 1'b0, 1'b0, 1, 17);

    // Back-pressure in OUT: beats offered must not be consumed
    bus.s_valid = 1'b1; bus.s_data = 8'h55; bus.s_last = 1'b0;
    repeat (20) tick();
    chk("hold_m_valid", bus.m_valid, 1);
    chk("hold_s_ready", bus.s_ready, 0);
    chk("hold_class",   bus.m_class, 1);
    bus.s_valid = 1'b0; bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    chk("ho_s_ready", bus.s_ready, 1);
    chk("ho_m_valid", bus.m_valid, 0);
    chk("keep_score", bus.m_score, 17);

    // Tie, acc_done on first RUN cycle, m_ready raised early
    send_frame(3, TOTAL, TOTAL - 1);
    finish_job(0, 5, 12, 12, -1, 1'b1, 1'b1, 1, 12);

    // All negative
    send_frame(7, TOTAL, TOTAL - 1);
    finish_job(2, -8, -2, -9, -2, 1'b0, 1'b1, 1, -2);

    // Early s_last on beat 10, then a clean frame
    send_frame(9, 11, 10);
    chk("early_last_err", frame_err, 1);
    chk("early_last_no_run", acc_en, 0);
    tick();
    chk("frame_err_pulse_end", frame_err, 0);
    send_frame(20, TOTAL, TOTAL - 1);
    chk("recover_acc_en", acc_en, 1);
    chk("recover_ifmap_0_0", ifmap_o[0][0], 20);
    finish_job(1, 100, -100, 0, 99, 1'b0, 1'b1, 0, 100);

    // Missing s_last on the final beat: last beat dropped, earlier beats kept
    send_frame(30, TOTAL, -1);
    chk("missing_last_err", frame_err, 1);
    chk("missing_last_acc_en", acc_en, 0);
    chk("missing_ifmap_7_7", ifmap_o[7][7], 93);
    chk("missing_w_2_1", weights_o[2][1], 30);
    chk("missing_w_2_2_kept", weights_o[2][2], 19);
    tick();

    // Reset in the middle of RUN
    send_frame(40, TOTAL, TOTAL - 1);
    tick(); tick();
    chk("pre_reset_acc_en", acc_en, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_reset_acc_en",  acc_en, 0);
    chk("mid_reset_s_ready", bus.s_ready, 1);
    chk("mid_reset_ifmap",   ifmap_o[7][7], 0);
    chk("mid_reset_weights", weights_o[0][0], 0);
    chk("mid_reset_busy",    busy, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
